// File: rtl/rgb_fade_sequencer_pkg.sv
// Shared types for the RGB keyframe sequencer: FSM states, keyframe record and the
// per-channel step decision used while fading.
package rgb_fade_sequencer_pkg;

  // Keyframe field widths; the sequencer's R and HOLD_W must not exceed these.
  localparam int unsigned KF_R      = 8;
  localparam int unsigned KF_HOLD_W = 8;

  typedef enum logic [1:0] {IDLE, FADE, HOLD} seq_state_t;

  typedef enum logic [1:0] {STEP_NONE, STEP_UP, STEP_DOWN} step_t;

  typedef struct packed {
    logic [KF_R-1:0]      red;
    logic [KF_R-1:0]      green;
    logic [KF_R-1:0]      blue;
    logic [KF_HOLD_W-1:0] hold;
  } keyframe_t;

  function automatic step_t step_toward(input logic [KF_R-1:0] cur,
                                        input logic [KF_R-1:0] tgt);
    if (cur < tgt) return STEP_UP;
    if (cur > tgt) return STEP_DOWN;
    return STEP_NONE;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Free-running divider: emits a one-cycle tick every TICK_DIV enabled cycles,
// with a synchronous clear that holds the count at zero.
module pwm_tick_gen #(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  assign tick = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Keyframe player for three PWM duty channels: fades one LSB per tick toward each frame,
// holds, then advances.  state | meaning
//   IDLE | table writable, duties frozen, waiting for start
//   FADE | stepping duties toward the current keyframe on each tick
//   HOLD | target reached, counting down the frame's hold ticks
module rgb_fade_sequencer
  import rgb_fade_sequencer_pkg::*;
#(
  parameter int unsigned R        = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TICK_DIV = 1_000_000,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [R-1:0]             cfg_red,
  input  logic [R-1:0]             cfg_green,
  input  logic [R-1:0]             cfg_blue,
  input  logic [HOLD_W-1:0]        cfg_hold,
  input  logic [$clog2(DEPTH):0]   num_frames,
  input  logic                     loop_en,
  input  logic                     start,
  input  logic                     stop,
  output logic [R:0]               red_duty,
  output logic [R:0]               green_duty,
  output logic [R:0]               blue_duty,
  output logic [$clog2(DEPTH)-1:0] frame_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] NF_MAX = (AW+1)'(DEPTH);

  keyframe_t      kf_q [DEPTH];
  seq_state_t     state_q, state_d;
  logic [AW-1:0]  frame_q, frame_d;
  logic [AW:0]    nf_q, nf_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [R-1:0]   duty_q [3];
  logic [R-1:0]   duty_d [3];
  logic           done_q, done_d;

  keyframe_t      kf_cur;
  logic [R-1:0]   tgt [3];
  logic           tick, at_target, last_frame;

  pwm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == IDLE),
    .en    (state_q != IDLE),
    .tick  (tick)
  );

  assign kf_cur     = kf_q[frame_q];
  assign tgt[0]     = R'(kf_cur.red);
  assign tgt[1]     = R'(kf_cur.green);
  assign tgt[2]     = R'(kf_cur.blue);
  assign at_target  = (duty_q[0] == tgt[0]) && (duty_q[1] == tgt[1]) && (duty_q[2] == tgt[2]);
  assign last_frame = ({1'b0, frame_q} == nf_q - (AW+1)'(1));

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    nf_d    = nf_q;
    hold_d  = hold_q;
    duty_d  = duty_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop && num_frames != '0 && num_frames <= NF_MAX) begin
          state_d = FADE;
          frame_d = '0;
          nf_d    = num_frames;
        end
      end
      FADE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (at_target) begin
          state_d = HOLD;
          hold_d  = HOLD_W'(kf_cur.hold);
        end else if (tick) begin
          for (int i = 0; i < 3; i++) begin
            case (step_toward(KF_R'(duty_q[i]), KF_R'(tgt[i])))
              STEP_UP:   duty_d[i] = duty_q[i] + R'(1);
              STEP_DOWN: duty_d[i] = duty_q[i] - R'(1);
              default:   duty_d[i] = duty_q[i];
            endcase
          end
        end
      end
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (hold_q == '0) begin
          if (!last_frame) begin
            frame_d = frame_q + AW'(1);
            state_d = FADE;
          end else if (loop_en) begin
            frame_d = '0;
            state_d = FADE;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (tick) begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      nf_q    <= '0;
      hold_q  <= '0;
      duty_q  <= '{default: '0};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      nf_q    <= nf_d;
      hold_q  <= hold_d;
      duty_q  <= duty_d;
      done_q  <= done_d;
    end
  end

  // Table survives reset so a host can replay without reloading.
  always_ff @(posedge clk) begin
    if (cfg_valid && cfg_ready)
      kf_q[cfg_addr] <= {KF_R'(cfg_red), KF_R'(cfg_green), KF_R'(cfg_blue), KF_HOLD_W'(cfg_hold)};
  end

  assign cfg_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign frame_idx  = frame_q;
  assign red_duty   = {1'b0, duty_q[0]};
  assign green_duty = {1'b0, duty_q[1]};
  assign blue_duty  = {1'b0, duty_q[2]};

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Bench for rgb_fade_sequencer: every expected output change is queued with the cycle it
// must appear on; a negedge monitor pops and compares each change the DUT makes.
module tb_rgb_fade_sequencer;

  localparam int R = 8, DEPTH = 8, TICK_DIV = 4, HOLD_W = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [2:0] cfg_addr = '0;
  logic [7:0] cfg_red = '0, cfg_green = '0, cfg_blue = '0, cfg_hold = '0;
  logic [3:0] num_frames = '0;
  logic       loop_en = 1'b0, start = 1'b0, stop = 1'b0;
  logic [8:0] red_duty, green_duty, blue_duty;
  logic [2:0] frame_idx;
  logic       busy, done;

  typedef struct {
    string       tag;
    int          cyc;
    logic [31:0] obs;
  } ev_t;

  ev_t         exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [31:0] prev_obs = '0;

  rgb_fade_sequencer #(.R(R), .DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .HOLD_W(HOLD_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_red    (cfg_red),
    .cfg_green  (cfg_green),
    .cfg_blue   (cfg_blue),
    .cfg_hold   (cfg_hold),
    .num_frames (num_frames),
    .loop_en    (loop_en),
    .start      (start),
    .stop       (stop),
    .red_duty   (red_duty),
    .green_duty (green_duty),
    .blue_duty  (blue_duty),
    .frame_idx  (frame_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Packed view of all outputs: busy, done, frame_idx, red, green, blue.
  function automatic logic [31:0] mk(input int b, input int d, input int f,
                                     input int r, input int g, input int bl);
    return {1'(b), 1'(d), 3'(f), 9'(r), 9'(g), 9'(bl)};
  endfunction

  task automatic ev(input string tag, input int c, input logic [31:0] o);
    ev_t e;
    e.tag = tag;
    e.cyc = c;
    e.obs = o;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [31:0] obs;
    ev_t         e;
    obs = {busy, done, frame_idx, red_duty, green_duty, blue_duty};
    if (mon_en && obs !== prev_obs) begin
      if (exp_q.size() == 0) begin
        chk("unexpected change", obs, prev_obs);
      end else begin
        e = exp_q.pop_front();
        chk({e.tag, " outputs"}, obs, e.obs);
        chk({e.tag, " cycle"}, cyc, e.cyc);
      end
    end
    prev_obs = obs;
  end

  task automatic wr(input int a, input int r, input int g, input int b, input int h,
                    input bit exp_rdy);
    @(negedge clk);
    chk("cfg_ready", cfg_ready, exp_rdy);
    cfg_valid = 1'b1;
    cfg_addr  = 3'(a);
    cfg_red   = 8'(r);
    cfg_green = 8'(g);
    cfg_blue  = 8'(b);
    cfg_hold  = 8'(h);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // arm returns the edge number on which start will be sampled; go then pulses start.
  task automatic arm(output int e);
    @(negedge clk);
    e = cyc + 1;
  endtask

  task automatic go(input int nf, input bit lp);
    num_frames = 4'(nf);
    loop_en    = lp;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic goto(input int c);
    int guard = 0;
    while (cyc < c && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("goto cycle", cyc, c);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    chk({tag, " pending events"}, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;

    // Reset values
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst red", red_duty, 0);
    chk("rst frame", frame_idx, 0);
    chk("rst cfg_ready", cfg_ready, 1);

    // Test 1: reset mid-FADE
    wr(0, 3, 0, 0, 1, 1'b1);
    arm(e);
    ev("t1 enter", e, mk(1, 0, 0, 0, 0, 0));
    ev("t1 red1", e + 4, mk(1, 0, 0, 1, 0, 0));
    go(1, 1'b0);
    goto(e + 6);
    chk("t1 pending", exp_q.size(), 0);
    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t1 async red", red_duty, 0);
    chk("t1 async busy", busy, 0);
    chk("t1 async frame", frame_idx, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t1 cfg_ready", cfg_ready, 1);
    mon_en = 1'b1;

    // Test 2: replay of the same table, single frame with hold 1
    arm(e);
    ev("t2 enter", e, mk(1, 0, 0, 0, 0, 0));
    ev("t2 red1", e + 4, mk(1, 0, 0, 1, 0, 0));
    ev("t2 red2", e + 8, mk(1, 0, 0, 2, 0, 0));
    ev("t2 red3", e + 12, mk(1, 0, 0, 3, 0, 0));
    ev("t2 done", e + 17, mk(0, 1, 0, 3, 0, 0));
    ev("t2 done off", e + 18, mk(0, 0, 0, 3, 0, 0));
    go(1, 1'b0);
    drain("t2");

    // Test 3: two frames looping, stopped after the wrap
    wr(0, 2, 2, 2, 0, 1'b1);
    wr(1, 0, 2, 5, 0, 1'b1);
    arm(e);
    ev("t3 enter", e, mk(1, 0, 0, 3, 0, 0));
    ev("t3 f0 s1", e + 4, mk(1, 0, 0, 2, 1, 1));
    ev("t3 f0 s2", e + 8, mk(1, 0, 0, 2, 2, 2));
    ev("t3 adv f1", e + 10, mk(1, 0, 1, 2, 2, 2));
    ev("t3 f1 s1", e + 12, mk(1, 0, 1, 1, 2, 3));
    ev("t3 f1 s2", e + 16, mk(1, 0, 1, 0, 2, 4));
    ev("t3 f1 s3", e + 20, mk(1, 0, 1, 0, 2, 5));
    ev("t3 wrap f0", e + 22, mk(1, 0, 0, 0, 2, 5));
    ev("t3 f0 s3", e + 24, mk(1, 0, 0, 1, 2, 4));
    ev("t3 f0 s4", e + 28, mk(1, 0, 0, 2, 2, 3));
    ev("t3 f0 s5", e + 32, mk(1, 0, 0, 2, 2, 2));
    ev("t3 adv f1 again", e + 34, mk(1, 0, 1, 2, 2, 2));
    ev("t3 f1 s4", e + 36, mk(1, 0, 1, 1, 2, 3));
    ev("t3 f1 s5", e + 40, mk(1, 0, 1, 0, 2, 4));
    ev("t3 stop", e + 42, mk(0, 0, 1, 0, 2, 4));
    go(2, 1'b1);
    goto(e + 41);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    drain("t3");

    // Test 4: start while busy is ignored; stop on a tick cycle freezes duties
    arm(e);
    ev("t4 enter", e, mk(1, 0, 0, 0, 2, 4));
    ev("t4 s1", e + 4, mk(1, 0, 0, 1, 2, 3));
    ev("t4 stop", e + 8, mk(0, 0, 0, 1, 2, 3));
    go(2, 1'b0);
    goto(e + 5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    goto(e + 7);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    drain("t4");

    // Test 5: settle on {5,5,5}, then two equal frames traversed without ticks
    wr(0, 5, 5, 5, 0, 1'b1);
    arm(e);
    ev("t5a enter", e, mk(1, 0, 0, 1, 2, 3));
    ev("t5a s1", e + 4, mk(1, 0, 0, 2, 3, 4));
    ev("t5a s2", e + 8, mk(1, 0, 0, 3, 4, 5));
    ev("t5a s3", e + 12, mk(1, 0, 0, 4, 5, 5));
    ev("t5a s4", e + 16, mk(1, 0, 0, 5, 5, 5));
    ev("t5a done", e + 18, mk(0, 1, 0, 5, 5, 5));
    ev("t5a done off", e + 19, mk(0, 0, 0, 5, 5, 5));
    go(1, 1'b0);
    drain("t5a");
    wr(1, 5, 5, 5, 0, 1'b1);
    arm(e);
    ev("t5b enter", e, mk(1, 0, 0, 5, 5, 5));
    ev("t5b adv f1", e + 2, mk(1, 0, 1, 5, 5, 5));
    ev("t5b done", e + 4, mk(0, 1, 1, 5, 5, 5));
    ev("t5b done off", e + 5, mk(0, 0, 1, 5, 5, 5));
    go(2, 1'b0);
    drain("t5b");

    // Test 6: out-of-range num_frames, and writes refused while busy
    @(negedge clk);
    num_frames = 4'd0;
    start      = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6 nf0 busy", busy, 0);
    num_frames = 4'd9;
    repeat (3) @(negedge clk);
    chk("t6 nf9 busy", busy, 0);
    start = 1'b0;
    wr(0, 5, 5, 5, 3, 1'b1);
    arm(e);
    ev("t6 enter", e, mk(1, 0, 0, 5, 5, 5));
    ev("t6 done", e + 13, mk(0, 1, 0, 5, 5, 5));
    ev("t6 done off", e + 14, mk(0, 0, 0, 5, 5, 5));
    go(1, 1'b0);
    goto(e + 5);
    wr(0, 9, 9, 9, 0, 1'b0);
    drain("t6 play");
    arm(e);
    ev("t6 replay enter", e, mk(1, 0, 0, 5, 5, 5));
    ev("t6 replay done", e + 13, mk(0, 1, 0, 5, 5, 5));
    ev("t6 replay done off", e + 14, mk(0, 0, 0, 5, 5, 5));
    go(1, 1'b0);
    drain("t6 replay");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
